// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port flip-flop register file.
package regfile_mp_pkg;

    // Default geometry of the register file.
    localparam int unsigned DefAddrWidth = 4;
    localparam int unsigned DefNumWords  = 2 ** DefAddrWidth;

    // Upper bound on address width handled by the one-hot helper.
    localparam int unsigned MaxAddrWidth = 10;
    localparam int unsigned MaxWords     = 2 ** MaxAddrWidth;

    // One-hot word select; all zeros when the request is not enabled.
    // Callers zero-extend the address and truncate the result to their size.
    function automatic logic [MaxWords-1:0] onehot_addr(
        input logic [MaxAddrWidth-1:0] addr,
        input logic                    en
    );
        logic [MaxWords-1:0] sel;
        sel = '0;
        if (en) begin
            sel[addr] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port arbiter: decides which same-cycle write requests survive to the
// sample stage and detects address collisions between enabled ports.
module regfile_wr_arb #(
    parameter int unsigned AddrWidth = 4,
    parameter int unsigned NumWr     = 2,
    parameter bit          ZeroReg   = 1'b1
) (
    input  logic [NumWr-1:0]                we_i,
    input  logic [NumWr-1:0][AddrWidth-1:0] waddr_i,
    output logic [NumWr-1:0]                keep_o,
    output logic                            coll_o
);

    // Requests that are enabled and not aimed at a hard-wired word 0.
    logic [NumWr-1:0] live;

    // Highest-index port wins an address; any shared live address is a collision.
    always_comb begin
        live   = '0;
        keep_o = '0;
        coll_o = 1'b0;
        for (int p = 0; p < int'(NumWr); p++) begin
            live[p] = we_i[p] && !(ZeroReg && (waddr_i[p] == '0));
        end
        for (int p = 0; p < int'(NumWr); p++) begin
            keep_o[p] = live[p];
            for (int q = p + 1; q < int'(NumWr); q++) begin
                if (we_i[q] && (waddr_i[q] == waddr_i[p])) begin
                    keep_o[p] = 1'b0;
                    // A live p implies a live q at the same address.
                    if (live[p]) begin
                        coll_o = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port flip-flop register file. Writes are sampled into a one-entry
// per-port stage, forwarded to all read ports from there, and committed to
// the word array on the following edge.
//
// Handshake: there is none; we_i is a fire-and-forget write strobe sampled
// on every clk_int rising edge, and reads are purely combinational.
module regfile_multiport
    import regfile_mp_pkg::*;
#(
    parameter int unsigned          AddrWidth   = DefAddrWidth,
    parameter int unsigned          DataWidth   = 16,
    parameter int unsigned          NumRd       = 2,
    parameter int unsigned          NumWr       = 2,
    parameter bit                   ZeroReg     = 1'b1,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                            clk_int,
    input  logic                            rst_ni,
    input  logic [NumRd-1:0][AddrWidth-1:0] raddr_i,
    output logic [NumRd-1:0][DataWidth-1:0] rdata_o,
    input  logic [NumWr-1:0][AddrWidth-1:0] waddr_i,
    input  logic [NumWr-1:0][DataWidth-1:0] wdata_i,
    input  logic [NumWr-1:0]                we_i,
    output logic                            coll_o,
    input  logic                            clr_err_i,
    output logic                            err_o
);

    localparam int unsigned NumWords = 2 ** AddrWidth;

    // One staged write per port; 'we' doubles as the entry's valid bit.
    typedef struct packed {
        logic                 we;
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] data;
    } wr_req_t;

    wr_req_t [NumWr-1:0]                stage_q;
    logic    [NumWr-1:0]                keep;
    logic                               coll;
    logic    [NumWr-1:0][NumWords-1:0]  commit_sel;
    logic    [DataWidth-1:0]            mem_q [NumWords];

    regfile_wr_arb #(
        .AddrWidth (AddrWidth),
        .NumWr     (NumWr),
        .ZeroReg   (ZeroReg)
    ) u_wr_arb (
        .we_i    (we_i),
        .waddr_i (waddr_i),
        .keep_o  (keep),
        .coll_o  (coll)
    );

    // Sample stage: valid every edge, address/data only on an enabled port.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            for (int p = 0; p < int'(NumWr); p++) begin
                stage_q[p].we <= keep[p];
                if (we_i[p]) begin
                    stage_q[p].addr <= waddr_i[p];
                    stage_q[p].data <= wdata_i[p];
                end
            end
        end
    end

    // Decode each valid stage entry into a one-hot word select.
    always_comb begin
        commit_sel = '0;
        for (int p = 0; p < int'(NumWr); p++) begin
            commit_sel[p] = NumWords'(onehot_addr(MaxAddrWidth'(stage_q[p].addr),
                                                   stage_q[p].we));
        end
    end

    // Commit staged writes; stage addresses are unique so selects never overlap.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < int'(NumWords); w++) begin
                mem_q[w] <= WordZeroVal;
            end
        end else begin
            for (int w = 0; w < int'(NumWords); w++) begin
                for (int p = 0; p < int'(NumWr); p++) begin
                    if (commit_sel[p][w]) begin
                        mem_q[w] <= stage_q[p].data;
                    end
                end
            end
        end
    end

    // Read path: forwarded stage entry, else constant word 0, else memory.
    always_comb begin
        rdata_o = '0;
        for (int r = 0; r < int'(NumRd); r++) begin
            rdata_o[r] = mem_q[raddr_i[r]];
            if (ZeroReg && (raddr_i[r] == '0)) begin
                rdata_o[r] = WordZeroVal;
            end
            for (int p = 0; p < int'(NumWr); p++) begin
                if (stage_q[p].we && (stage_q[p].addr == raddr_i[r])) begin
                    rdata_o[r] = stage_q[p].data;
                end
            end
        end
    end

    // Collision pulse and sticky error; a new collision beats a clear.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            coll_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            coll_o <= coll;
            err_o  <= coll | (err_o & ~clr_err_i);
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: one ZeroReg=1 and one ZeroReg=0 instance share
// stimulus and are checked against a word-level reference model.
module tb_regfile_multiport;

    logic                 clk_int;
    logic                 rst_ni;
    logic [1:0][3:0]      raddr;
    logic [1:0][3:0]      waddr;
    logic [1:0][15:0]     wdata;
    logic [1:0]           we;
    logic                 clr_err;
    logic [1:0][15:0]     rdata_z, rdata_n;
    logic                 coll_z, coll_n, err_z, err_n;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents visible to a read, one image per instance
    // (index 0: ZeroReg=1, index 1: ZeroReg=0).
    logic [15:0] vis [2][16];
    logic [1:0]  exp_coll;
    logic [1:0]  exp_err;

    regfile_multiport #(.ZeroReg(1'b1)) dut_z (
        .clk_int(clk_int), .rst_ni(rst_ni), .raddr_i(raddr), .rdata_o(rdata_z),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .coll_o(coll_z),
        .clr_err_i(clr_err), .err_o(err_z)
    );

    regfile_multiport #(.ZeroReg(1'b0)) dut_n (
        .clk_int(clk_int), .rst_ni(rst_ni), .raddr_i(raddr), .rdata_o(rdata_n),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .coll_o(coll_n),
        .clr_err_i(clr_err), .err_o(err_n)
    );

    // Clock
    initial clk_int = 1'b0;
    always #5 clk_int = ~clk_int;

    // Model: a word written in a cycle becomes readable right after that edge;
    // the highest enabled port wins, word 0 ignores writes when hard-wired.
    always @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 2; k++)
                for (int w = 0; w < 16; w++) vis[k][w] = 16'h0000;
            exp_coll = '0;
            exp_err  = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic c;
                c = 1'b0;
                for (int p = 0; p < 2; p++)
                    if (we[p] && !(k == 0 && waddr[p] == 4'd0)) vis[k][waddr[p]] = wdata[p];
                for (int p = 0; p < 2; p++)
                    for (int q = p + 1; q < 2; q++)
                        if (we[p] && we[q] && waddr[p] == waddr[q] && !(k == 0 && waddr[p] == 4'd0))
                            c = 1'b1;
                exp_coll[k] = c;
                exp_err[k]  = c | (exp_err[k] & ~clr_err);
            end
        end
    end

    function automatic logic [15:0] exp_rd(input int k, input logic [3:0] a);
        if (k == 0 && a == 4'd0) return 16'h0000;
        return vis[k][a];
    endfunction

    function automatic logic [15:0] act_rd(input int k, input int r);
        return (k == 0) ? rdata_z[r] : rdata_n[r];
    endfunction

    // Driver: change inputs on the falling edge, settle, then let the caller check.
    task automatic drive(input logic [1:0] w, input logic [3:0] a0, input logic [15:0] d0,
                         input logic [3:0] a1, input logic [15:0] d1,
                         input logic [3:0] r0, input logic [3:0] r1, input logic clr);
        @(negedge clk_int);
        we = w; waddr[0] = a0; wdata[0] = d0; waddr[1] = a1; wdata[1] = d1;
        raddr[0] = r0; raddr[1] = r1; clr_err = clr;
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; we = '0; waddr = '0; wdata = '0; raddr = '0; clr_err = 1'b0;
        repeat (2) @(negedge clk_int);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int a = 0; a < 16; a++) begin
            drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 4'(a), 4'(15 - a), 1'b0);
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 2; r++) begin
                    checks++;
                    if (act_rd(k, r) !== 16'h0000) begin
                        failures++;
                        $display("FAIL reset_word inst%0d port%0d addr=%0d got=%h exp=0000",
                                 k, r, raddr[r], act_rd(k, r));
                    end
                end
            end
        end
        checks++;
        if ({coll_z, coll_n, err_z, err_n} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got coll=%b%b err=%b%b exp all 0", coll_z, coll_n, err_z, err_n);
        end
    endtask

    task automatic test_latency();
        logic [15:0] exp_seq [4];
        exp_seq[0] = 16'h0000; exp_seq[1] = 16'hBEEF; exp_seq[2] = 16'hBEEF; exp_seq[3] = 16'hBEEF;
        for (int c = 0; c < 4; c++) begin
            drive((c == 0) ? 2'b01 : 2'b00, 4'd3, 16'hBEEF, 4'd0, 16'h0, 4'd3, 4'd3, 1'b0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_rd(k, 0) !== exp_seq[c]) begin
                    failures++;
                    $display("FAIL latency inst%0d cycle%0d got=%h exp=%h", k, c, act_rd(k, 0), exp_seq[c]);
                end
            end
        end
    endtask

    task automatic test_collision();
        drive(2'b11, 4'd5, 16'h1111, 4'd5, 16'h2222, 4'd5, 4'd5, 1'b0);
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 4'd5, 4'd5, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_rd(k, 1) !== 16'h2222) begin
                failures++;
                $display("FAIL coll_winner inst%0d got=%h exp=2222", k, act_rd(k, 1));
            end
        end
        checks++;
        if ({coll_z, coll_n, err_z, err_n} !== 4'b1111) begin
            failures++;
            $display("FAIL coll_pulse got coll=%b%b err=%b%b exp 11 11", coll_z, coll_n, err_z, err_n);
        end
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 4'd5, 4'd5, 1'b1);
        checks++;
        if ({coll_z, coll_n, err_z, err_n} !== 4'b0011) begin
            failures++;
            $display("FAIL coll_hold got coll=%b%b err=%b%b exp 00 11", coll_z, coll_n, err_z, err_n);
        end
        drive(2'b11, 4'd6, 16'h3333, 4'd6, 16'h4444, 4'd6, 4'd5, 1'b1);
        checks++;
        if ({err_z, err_n} !== 2'b00) begin
            failures++;
            $display("FAIL err_clear got err=%b%b exp 00", err_z, err_n);
        end
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 4'd6, 4'd5, 1'b0);
        checks++;
        if ({coll_z, coll_n, err_z, err_n} !== 4'b1111 || rdata_z[0] !== 16'h4444) begin
            failures++;
            $display("FAIL set_beats_clear got coll=%b%b err=%b%b rd=%h exp 11 11 4444",
                     coll_z, coll_n, err_z, err_n, rdata_z[0]);
        end
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b1);
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_zero_reg();
        drive(2'b11, 4'd0, 16'hFFFF, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1'b0);
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (rdata_z[0] !== 16'h0000 || coll_z !== 1'b0 || err_z !== 1'b0) begin
            failures++;
            $display("FAIL zero_hardwired got rd=%h coll=%b err=%b exp 0000 0 0", rdata_z[0], coll_z, err_z);
        end
        checks++;
        if (rdata_n[0] !== 16'hFFFF || coll_n !== 1'b1) begin
            failures++;
            $display("FAIL zero_ordinary got rd=%h coll=%b exp ffff 1", rdata_n[0], coll_n);
        end
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (rdata_n[0] !== 16'hFFFF || rdata_z[0] !== 16'h0000) begin
            failures++;
            $display("FAIL zero_after_commit got z=%h n=%h exp 0000 ffff", rdata_z[0], rdata_n[0]);
        end
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_seq [4];
        exp_seq[0] = 16'h0000; exp_seq[1] = 16'hA5A5; exp_seq[2] = 16'h5A5A; exp_seq[3] = 16'h5A5A;
        for (int c = 0; c < 4; c++) begin
            drive((c < 2) ? 2'b01 : 2'b00, 4'd7, (c == 0) ? 16'hA5A5 : 16'h5A5A,
                  4'd0, 16'h0, 4'd7, 4'd7, 1'b0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_rd(k, 0) !== exp_seq[c] || act_rd(k, 1) !== exp_seq[c]) begin
                    failures++;
                    $display("FAIL back_to_back inst%0d cycle%0d got=%h/%h exp=%h",
                             k, c, act_rd(k, 0), act_rd(k, 1), exp_seq[c]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        drive(2'b01, 4'd9, 16'h1234, 4'd0, 16'h0, 4'd9, 4'd9, 1'b0);
        @(posedge clk_int);
        #2 rst_ni = 1'b0;
        #2 rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 4'd9, 4'd9, 1'b0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_rd(k, 0) !== 16'h0000) begin
                    failures++;
                    $display("FAIL reset_mid_write inst%0d cycle%0d got=%h exp=0000", k, c, act_rd(k, 0));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 7)), 16'($urandom),
                  4'($urandom_range(0, 7)), 16'($urandom),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0));
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 2; r++) begin
                    checks++;
                    if (act_rd(k, r) !== exp_rd(k, raddr[r])) begin
                        failures++;
                        $display("FAIL random_read n=%0d inst%0d port%0d addr=%0d got=%h exp=%h",
                                 n, k, r, raddr[r], act_rd(k, r), exp_rd(k, raddr[r]));
                    end
                end
            end
            checks++;
            if ({coll_z, coll_n} !== {exp_coll[0], exp_coll[1]} ||
                {err_z, err_n} !== {exp_err[0], exp_err[1]}) begin
                failures++;
                $display("FAIL random_flags n=%0d got coll=%b%b err=%b%b exp coll=%b%b err=%b%b",
                         n, coll_z, coll_n, err_z, err_n, exp_coll[0], exp_coll[1], exp_err[0], exp_err[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_collision();
        test_zero_reg();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
